// File: rtl/uart_rx_port_pkg.sv
// Shared types and constants for the OrgaSmall UART receive port.
// Interrupt bit positions match what the system's change-detecting controller expects.
package orga_small_uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    localparam int INT_BIT_RX           = 0;
    localparam int INT_BIT_FERR         = 1;
    localparam int DEFAULT_CLKS_PER_BIT = 16;

endpackage

// File: rtl/uart_rx_port_if.sv
// Bundle between the serial line / system ports and the UART receiver.
// The slave side is the receiver; the master side is the line driver plus the system.
interface uart_rx_port_if;

    logic       rx;
    logic [7:0] portInput;
    logic [7:0] portInterrupt;
    logic       rxValid;
    logic       busy;

    modport master (
        output rx,
        input  portInput,
        input  portInterrupt,
        input  rxValid,
        input  busy
    );

    modport slave (
        input  rx,
        output portInput,
        output portInterrupt,
        output rxValid,
        output busy
    );

endinterface

// File: rtl/uart_rx_port_sync.sv
// Two-flop synchronizer on the falling clock edge; resets to the idle-high line level
// so that reset release never looks like a start bit.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Metastability filter chain
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_port.sv
// 8N1 UART receiver feeding portInput/portInterrupt of the OrgaSmall system.
// Good bytes toggle interrupt bit0, framing errors toggle bit1; everything updates on negedge clk.
module uart_rx_port
    import orga_small_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic           clk,
    input  logic           reset,
    uart_rx_port_if.slave  bus
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic             rxs_s;
    logic             rxs_prev_q;
    rx_state_t        state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [2:0]       bit_q,    bit_d;
    logic [7:0]       shift_q,  shift_d;
    logic [7:0]       data_q,   data_d;
    logic [1:0]       irq_q,    irq_d;
    logic             valid_q,  valid_d;
    logic             busy_q;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (bus.rx),
        .q_o   (rxs_s)
    );

    // State, counters and registered outputs
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            rxs_prev_q <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= 3'd0;
            shift_q    <= 8'h00;
            data_q     <= 8'h00;
            irq_q      <= 2'b00;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            rxs_prev_q <= rxs_s;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            irq_q      <= irq_d;
            valid_q    <= valid_d;
            busy_q     <= (state_d != IDLE);
        end
    end

    // Frame sequencing: start validation, mid-bit sampling, stop check, break recovery
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        irq_d   = irq_q;
        valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rxs_prev_q && !rxs_s) begin
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end

            START: begin
                if (cnt_q == HALF_CNT) begin
                    if (rxs_s) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = DATA;
                        cnt_d   = '0;
                        bit_d   = 3'd0;
                    end
                end else begin
                    state_d = START;
                end
            end

            DATA: begin
                if (cnt_q == LAST_CNT) begin
                    shift_d = {rxs_s, shift_q[7:1]};
                    cnt_d   = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    state_d = DATA;
                end
            end

            STOP: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    if (rxs_s) begin
                        data_d             = shift_q;
                        irq_d[INT_BIT_RX]  = ~irq_q[INT_BIT_RX];
                        valid_d            = 1'b1;
                        state_d            = IDLE;
                    end else begin
                        irq_d[INT_BIT_FERR] = ~irq_q[INT_BIT_FERR];
                        state_d             = BREAK;
                    end
                end else begin
                    state_d = STOP;
                end
            end

            // A held-low line must report only one error, so wait for idle-high first
            BREAK: begin
                cnt_d = '0;
                if (rxs_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = BREAK;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.portInput     = data_q;
    assign bus.portInterrupt = {6'b000000, irq_q};
    assign bus.rxValid       = valid_q;
    assign bus.busy          = busy_q;

endmodule

// File: tb/tb_uart_rx_port.sv
// Bench for uart_rx_port: table of frames with expected port state, a scoreboard of
// expected bytes checked on every rxValid pulse, and hand-written glitch/reset sequences.
module tb_uart_rx_port;
    import orga_small_uart_pkg::*;

    localparam int CPB = 16;
    // rx driven low on a rising edge reaches the FSM on the 3rd falling edge (D), and
    // the stop sample is D + CPB/2 + 9*CPB; both counted in falling edges from the drive.
    localparam int LAT = 3 + CPB / 2 + 9 * CPB;

    logic clk = 1'b0;
    logic reset;
    uart_rx_port_if bus ();

    uart_rx_port #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(negedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        int         start;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    int   ferr_cnt  = 0;
    logic prev_ferr = 1'b0;

    // Monitor: scoreboard pop on rxValid, framing-error toggle counting
    always @(posedge clk) begin
        if (reset) begin
            ferr_cnt  = 0;
            prev_ferr = 1'b0;
        end else begin
            if (bus.portInterrupt[INT_BIT_FERR] !== prev_ferr) ferr_cnt++;
            prev_ferr = bus.portInterrupt[INT_BIT_FERR];
            if (bus.rxValid === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_rxValid", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("rx_data", {24'd0, bus.portInput}, {24'd0, mon_e.data});
                    check("rx_latency", cyc - mon_e.start, LAT);
                end
            end
        end
    end

    // Called right after a rising edge; returns right after a rising edge.
    task automatic send_frame(input logic [7:0] d, input logic stop, input bit push);
        exp_t e;
        bus.rx = 1'b0;
        if (push) begin
            e.data  = d;
            e.start = cyc;
            sb.push_back(e);
        end
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rx = d[i];
            repeat (CPB) @(posedge clk);
        end
        bus.rx = stop;
        repeat (CPB) @(posedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        check("rst_portInput", {24'd0, bus.portInput}, 32'h00);
        check("rst_portInterrupt", {24'd0, bus.portInterrupt}, 32'h00);
        check("rst_rxValid", {31'd0, bus.rxValid}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    typedef struct {
        bit         do_rst;
        int         pre_low;
        logic [7:0] data;
        logic       stop;
        int         gap;
        logic [7:0] exp_in;
        logic [7:0] exp_irq;
        logic       exp_busy;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{1'b1, 0,  8'hA5, 1'b1, 2, 8'hA5, 8'h01, 1'b0, 0};
        vecs[1] = '{1'b1, 0,  8'h3C, 1'b1, 0, 8'h3C, 8'h01, 1'b0, 0};
        vecs[2] = '{1'b0, 0,  8'h81, 1'b1, 2, 8'h81, 8'h00, 1'b0, 0};
        vecs[3] = '{1'b1, 0,  8'h55, 1'b0, 0, 8'h00, 8'h02, 1'b1, 1};
        vecs[4] = '{1'b0, 40, 8'h12, 1'b1, 2, 8'h12, 8'h03, 1'b0, 1};

        reset  = 1'b1;
        bus.rx = 1'b1;
        repeat (3) @(posedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        for (int v = 0; v < 5; v++) begin
            if (vecs[v].do_rst) do_reset();
            if (vecs[v].pre_low > 0) begin
                bus.rx = 1'b0;
                repeat (vecs[v].pre_low * CPB) @(posedge clk);
                bus.rx = 1'b1;
                repeat (CPB) @(posedge clk);
            end
            send_frame(vecs[v].data, vecs[v].stop, vecs[v].stop);
            bus.rx = 1'b1;
            repeat (vecs[v].gap * CPB) @(posedge clk);
            check($sformatf("vec%0d_portInput", v), {24'd0, bus.portInput}, {24'd0, vecs[v].exp_in});
            check($sformatf("vec%0d_portInterrupt", v), {24'd0, bus.portInterrupt}, {24'd0, vecs[v].exp_irq});
            check($sformatf("vec%0d_busy", v), {31'd0, bus.busy}, {31'd0, vecs[v].exp_busy});
            check($sformatf("vec%0d_ferr_toggles", v), ferr_cnt, vecs[v].exp_ferr);
        end

        // Short low glitch: busy from D (3rd edge) until the start sample at D+8
        bus.rx = 1'b0;
        begin
            int st;
            st = cyc;
            for (int k = 1; k <= 14; k++) begin
                @(posedge clk);
                if (k == 3) bus.rx = 1'b1;
                check($sformatf("glitch_busy_k%0d", k), {31'd0, bus.busy},
                      {31'd0, ((cyc - st) >= 3 && (cyc - st) < 11)});
            end
        end
        check("glitch_portInput", {24'd0, bus.portInput}, 32'h12);
        check("glitch_portInterrupt", {24'd0, bus.portInterrupt}, 32'h03);

        // Reset in the middle of data bit 4 of 0xF0
        fork
            send_frame(8'hF0, 1'b1, 1'b0);
            begin
                repeat (CPB * 5 + CPB / 2) @(posedge clk);
                reset = 1'b1;
                #1;
                check("midrst_portInput", {24'd0, bus.portInput}, 32'h00);
                check("midrst_portInterrupt", {24'd0, bus.portInterrupt}, 32'h00);
                check("midrst_rxValid", {31'd0, bus.rxValid}, 32'd0);
                check("midrst_busy", {31'd0, bus.busy}, 32'd0);
                @(posedge clk);
                @(posedge clk);
                reset = 1'b0;
            end
        join
        bus.rx = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        send_frame(8'h0F, 1'b1, 1'b1);
        bus.rx = 1'b1;
        repeat (CPB) @(posedge clk);
        check("post_rst_portInput", {24'd0, bus.portInput}, 32'h0F);
        check("post_rst_portInterrupt", {24'd0, bus.portInterrupt}, 32'h01);
        check("post_rst_busy", {31'd0, bus.busy}, 32'd0);
        check("post_rst_ferr_toggles", ferr_cnt, 0);

        check("scoreboard_drain", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
